// File: rtl/instruction_fetch.sv
// Instruction fetch stage: requests one word at a time from instruction memory,
// buffers it for decode and steers the program counter (hold/increment/load/reset).
module instruction_fetch #(
    parameter int ANCHO       = 16,
    parameter int ANCHO_INSTR = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [ANCHO-1:0]       pc_i,
    output logic [1:0]             pc_op_o,
    output logic [ANCHO-1:0]       pc_load_o,
    output logic                   mem_req_o,
    output logic [ANCHO-1:0]       mem_addr_o,
    input  logic                   mem_ack_i,
    input  logic [ANCHO_INSTR-1:0] mem_data_i,
    output logic [ANCHO_INSTR-1:0] instr_o,
    output logic [ANCHO-1:0]       instr_pc_o,
    output logic                   instr_valid_o,
    input  logic                   instr_ready_i,
    input  logic                   flush_i,
    input  logic [ANCHO-1:0]       flush_addr_i
);

    localparam logic [1:0] PC_HOLD  = 2'b00;
    localparam logic [1:0] PC_INC   = 2'b01;
    localparam logic [1:0] PC_LOAD  = 2'b10;
    localparam logic [1:0] PC_RESET = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        FULL  = 2'b10
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [ANCHO_INSTR-1:0] instr_q;
    logic [ANCHO-1:0]       instr_pc_q;
    logic                   valid_q;
    logic                   capture;
    logic                   transfer;

    // Reset beats flush, and flush beats any ack or handshake arriving in the same cycle.
    always_comb begin
        state_d   = state_q;
        pc_op_o   = PC_HOLD;
        pc_load_o = '0;
        mem_req_o = 1'b0;
        capture   = 1'b0;
        transfer  = 1'b0;
        if (rst_i) begin
            pc_op_o = PC_RESET;
            state_d = IDLE;
        end else if (flush_i) begin
            pc_op_o   = PC_LOAD;
            pc_load_o = flush_addr_i;
            state_d   = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = FETCH;
                end
                FETCH: begin
                    mem_req_o = 1'b1;
                    if (mem_ack_i) begin
                        pc_op_o = PC_INC;
                        capture = 1'b1;
                        state_d = FULL;
                    end
                end
                FULL: begin
                    if (valid_q && instr_ready_i) begin
                        transfer = 1'b1;
                        state_d  = FETCH;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (flush_i) begin
                valid_q <= 1'b0;
            end else if (capture) begin
                instr_q    <= mem_data_i;
                instr_pc_q <= pc_i;
                valid_q    <= 1'b1;
            end else if (transfer) begin
                valid_q <= 1'b0;
            end
        end
    end

    // Valid is masked during reset so decode never sees a stale word before the first edge.
    assign mem_addr_o    = pc_i;
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign instr_valid_o = valid_q & ~rst_i;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a small program-counter model, directed per-cycle
// stimulus, and a scoreboard monitor that checks every instruction handed to decode.
module tb_instruction_fetch;

    logic        clk;
    logic        rst;
    logic [15:0] pc;
    logic [1:0]  pc_op;
    logic [15:0] pc_load;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_data;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        flush;
    logic [15:0] flush_addr;

    int total = 0;
    int bad = 0;
    int transfers = 0;
    logic [31:0] exp_q[$];

    instruction_fetch #(.ANCHO(16), .ANCHO_INSTR(16)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .pc_i         (pc),
        .pc_op_o      (pc_op),
        .pc_load_o    (pc_load),
        .mem_req_o    (mem_req),
        .mem_addr_o   (mem_addr),
        .mem_ack_i    (mem_ack),
        .mem_data_i   (mem_data),
        .instr_o      (instr),
        .instr_pc_o   (instr_pc),
        .instr_valid_o(instr_valid),
        .instr_ready_i(instr_ready),
        .flush_i      (flush),
        .flush_addr_i (flush_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Program counter that the fetch stage drives through pc_op.
    always @(posedge clk) begin
        case (pc_op)
            2'b01:   pc <= pc + 16'h0001;
            2'b10:   pc <= pc_load;
            2'b11:   pc <= 16'h0000;
            default: pc <= pc;
        endcase
    end

    task automatic compareField(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic ack, input logic [15:0] data,
                                 input logic ready, input logic fl, input logic [15:0] faddr);
        @(negedge clk);
        rst         = r;
        mem_ack     = ack;
        mem_data    = data;
        instr_ready = ready;
        flush       = fl;
        flush_addr  = faddr;
    endtask

    task automatic checkOutput(input string tag, input logic exp_req, input logic [15:0] exp_addr,
                               input logic [1:0] exp_op, input logic [15:0] exp_load, input logic exp_valid);
        #2;
        compareField({tag, ".mem_req"}, {31'd0, mem_req}, {31'd0, exp_req});
        if (exp_req)
            compareField({tag, ".mem_addr"}, {16'd0, mem_addr}, {16'd0, exp_addr});
        compareField({tag, ".pc_op"}, {30'd0, pc_op}, {30'd0, exp_op});
        compareField({tag, ".pc_load"}, {16'd0, pc_load}, {16'd0, exp_load});
        compareField({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, exp_valid});
    endtask

    // Scoreboard monitor: every accepted handoff must match the oldest expected word.
    initial begin
        logic [31:0] exp_word;
        forever begin
            @(negedge clk);
            #3;
            if (rst === 1'b0 && instr_valid === 1'b1 && instr_ready === 1'b1 && flush === 1'b0) begin
                transfers++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_transfer: got %h@%h expected none", instr, instr_pc);
                end else begin
                    exp_word = exp_q.pop_front();
                    compareField("xfer.instr", {16'd0, instr}, {16'd0, exp_word[31:16]});
                    compareField("xfer.instr_pc", {16'd0, instr_pc}, {16'd0, exp_word[15:0]});
                end
            end
        end
    end

    initial begin
        rst = 1'b1; mem_ack = 1'b0; mem_data = 16'h0; instr_ready = 1'b0;
        flush = 1'b0; flush_addr = 16'h0;

        applyStimulus(1, 0, 16'h0000, 0, 0, 16'h0000);
        checkOutput("rst0", 0, 16'h0000, 2'b11, 16'h0000, 0);
        applyStimulus(1, 0, 16'h0000, 0, 1, 16'h0055);
        checkOutput("rst1", 0, 16'h0000, 2'b11, 16'h0000, 0);
        compareField("rst.instr", {16'd0, instr}, 32'h0);
        compareField("rst.instr_pc", {16'd0, instr_pc}, 32'h0);

        applyStimulus(0, 0, 16'h0000, 0, 0, 16'h0000);
        checkOutput("idle0", 0, 16'h0000, 2'b00, 16'h0000, 0);
        applyStimulus(0, 0, 16'h0000, 1, 0, 16'h0000);
        checkOutput("fetch_wait", 1, 16'h0000, 2'b00, 16'h0000, 0);
        applyStimulus(0, 1, 16'h1234, 1, 0, 16'h0000);
        exp_q.push_back({16'h1234, 16'h0000});
        checkOutput("fetch_ack0", 1, 16'h0000, 2'b01, 16'h0000, 0);
        applyStimulus(0, 0, 16'h0000, 1, 0, 16'h0000);
        checkOutput("full_xfer0", 0, 16'h0000, 2'b00, 16'h0000, 1);

        // Decode stalls for five cycles on the second word.
        applyStimulus(0, 1, 16'h5678, 0, 0, 16'h0000);
        exp_q.push_back({16'h5678, 16'h0001});
        checkOutput("fetch_ack1", 1, 16'h0001, 2'b01, 16'h0000, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 16'h0000, 0, 0, 16'h0000);
            checkOutput("stall", 0, 16'h0000, 2'b00, 16'h0000, 1);
        end
        applyStimulus(0, 0, 16'h0000, 1, 0, 16'h0000);
        checkOutput("full_xfer1", 0, 16'h0000, 2'b00, 16'h0000, 1);
        applyStimulus(0, 0, 16'h0000, 0, 0, 16'h0000);
        checkOutput("resume", 1, 16'h0002, 2'b00, 16'h0000, 0);

        // Flush coincident with ack: the word is discarded, PC loads 0040.
        applyStimulus(0, 1, 16'hDEAD, 0, 1, 16'h0040);
        checkOutput("flush_ack", 0, 16'h0000, 2'b10, 16'h0040, 0);
        applyStimulus(0, 0, 16'h0000, 0, 0, 16'h0000);
        checkOutput("idle_after_flush", 0, 16'h0000, 2'b00, 16'h0000, 0);
        applyStimulus(0, 1, 16'h9ABC, 0, 0, 16'h0000);
        checkOutput("fetch_0040", 1, 16'h0040, 2'b01, 16'h0000, 0);
        applyStimulus(0, 0, 16'h0000, 0, 0, 16'h0000);
        checkOutput("full_hold", 0, 16'h0000, 2'b00, 16'h0000, 1);

        // Flush together with ready in FULL: 9ABC is dropped, never handed over.
        applyStimulus(0, 0, 16'h0000, 1, 1, 16'hFFFF);
        checkOutput("flush_full", 0, 16'h0000, 2'b10, 16'hFFFF, 1);
        applyStimulus(0, 0, 16'h0000, 1, 0, 16'h0000);
        checkOutput("idle_after_drop", 0, 16'h0000, 2'b00, 16'h0000, 0);

        applyStimulus(0, 1, 16'hBEEF, 1, 0, 16'h0000);
        exp_q.push_back({16'hBEEF, 16'hFFFF});
        checkOutput("fetch_ffff", 1, 16'hFFFF, 2'b01, 16'h0000, 0);
        applyStimulus(0, 0, 16'h0000, 1, 0, 16'h0000);
        checkOutput("full_xfer2", 0, 16'h0000, 2'b00, 16'h0000, 1);
        applyStimulus(0, 0, 16'h0000, 1, 0, 16'h0000);
        checkOutput("wrap", 1, 16'h0000, 2'b00, 16'h0000, 0);

        // Reset mid-request with an ack: nothing is captured.
        applyStimulus(1, 1, 16'h7777, 1, 0, 16'h0000);
        checkOutput("rst_ack", 0, 16'h0000, 2'b11, 16'h0000, 0);
        applyStimulus(0, 0, 16'h0000, 1, 0, 16'h0000);
        checkOutput("idle_after_rst", 0, 16'h0000, 2'b00, 16'h0000, 0);
        compareField("rst_ack.instr", {16'd0, instr}, 32'h0);
        compareField("rst_ack.instr_pc", {16'd0, instr_pc}, 32'h0);

        applyStimulus(0, 1, 16'h0F0F, 1, 0, 16'h0000);
        exp_q.push_back({16'h0F0F, 16'h0000});
        checkOutput("fetch_post_rst", 1, 16'h0000, 2'b01, 16'h0000, 0);
        applyStimulus(0, 0, 16'h0000, 1, 0, 16'h0000);
        checkOutput("full_xfer3", 0, 16'h0000, 2'b00, 16'h0000, 1);
        applyStimulus(0, 0, 16'h0000, 0, 0, 16'h0000);
        checkOutput("final_fetch", 1, 16'h0001, 2'b00, 16'h0000, 0);

        for (int i = 0; i < 3; i++)
            applyStimulus(0, 0, 16'h0000, 0, 0, 16'h0000);
        #4;
        compareField("scoreboard_empty", exp_q.size(), 32'd0);
        compareField("transfer_count", transfers, 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter ANCHO, default 16: PC and memory address width in bits.
REQ-002 Parameter ANCHO_INSTR, default 16: instruction word width in bits.
REQ-003 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 pc_i  input  ANCHO  current PC from the program counter's pc_o.
REQ-006 pc_op_o  output  2  operation request to the program counter's pc_op_i: 00 hold, 01 increment, 10 load pc_load_o, 11 reset to 0.
REQ-007 pc_load_o  output  ANCHO  load value for the program counter's pc_i.
REQ-008 mem_req_o  output  1  instruction memory read request.
REQ-009 mem_addr_o  output  ANCHO  read address.
REQ-010 mem_ack_i  input  1  single-cycle read completion; meaningful only while mem_req_o=1.
REQ-011 mem_data_i  input  ANCHO_INSTR  instruction word, valid in the mem_ack_i cycle.
REQ-012 instr_o  output  ANCHO_INSTR  fetched instruction to decode.
REQ-013 instr_pc_o  output  ANCHO  address of instr_o.
REQ-014 instr_valid_o  output  1  instr_o/instr_pc_o hold a valid instruction.
REQ-015 instr_ready_i  input  1  decode accepts the instruction.
REQ-016 flush_i  input  1  redirect request (branch/jump taken).
REQ-017 flush_addr_i  input  ANCHO  redirect target.

Function
REQ-018 FSM states SHALL be IDLE, FETCH and FULL, registered.
REQ-019 IDLE: mem_req_o=0, pc_op_o=00; next state FETCH unconditionally.
REQ-020 FETCH: mem_req_o=1, mem_addr_o=pc_i (combinational).
REQ-021 FETCH with mem_ack_i=1: instr_o<=mem_data_i, instr_pc_o<=pc_i, instr_valid_o<=1; pc_op_o=01 in that same cycle; next state FULL.
REQ-022 FETCH with mem_ack_i=0: pc_op_o=00, remain in FETCH, mem_addr_o stable.
REQ-023 FULL: mem_req_o=0, instr_valid_o=1, instr_o/instr_pc_o stable; pc_op_o=00.
REQ-024 Transfer SHALL occur when instr_valid_o=1, instr_ready_i=1, flush_i=0; then instr_valid_o<=0 and next state FETCH.
REQ-025 FULL with instr_ready_i=0: remain in FULL indefinitely.
REQ-026 flush_i=1 in any state (rst_i=0): pc_op_o=10, pc_load_o=flush_addr_i, mem_req_o=0 that cycle, instr_valid_o<=0, next state IDLE.
REQ-027 Flush coincident with mem_ack_i: the returned data SHALL be discarded and pc_op_o SHALL be 10, not 01.
REQ-028 Flush coincident with instr_ready_i in FULL: no transfer; instruction dropped.
REQ-029 pc_load_o SHALL equal flush_addr_i whenever flush_i=1, otherwise 0.
REQ-030 PC wrap-around (FFFF -> 0000 for ANCHO=16) is handled by the program counter; fetch SHALL issue address 0000 normally.
REQ-031 At most one memory request outstanding; at most one instruction buffered.

Reset
REQ-032 While rst_i=1: pc_op_o=11, pc_load_o=0, mem_req_o=0, instr_valid_o=0; state<=IDLE.
REQ-033 Next edge with rst_i=1: instr_o<=0 and instr_pc_o<=0.
REQ-034 Reset SHALL override flush_i, mem_ack_i and instr_ready_i in the same cycle.
REQ-035 Reset mid-request SHALL drop mem_req_o in that cycle; an ack arriving then is ignored.
REQ-036 The first request after reset release SHALL be issued two cycles after rst_i falls (IDLE, then FETCH), with address 0000.

Verification
REQ-037 Reset, pc_i=0000, ack after 1 cycle of FETCH with data 1234, ready=1 -> instr_o=1234, instr_pc_o=0000, valid 1 cycle, pc_op_o=01 in the ack cycle.
REQ-038 Decode holds instr_ready_i=0 for 5 cycles -> instr_valid_o stays 1, mem_req_o stays 0, pc_op_o=00 throughout; fetch resumes after ready.
REQ-039 flush_i with flush_addr_i=0040 during FETCH in the same cycle as mem_ack_i -> data discarded, pc_op_o=10, pc_load_o=0040, next request address 0040.
REQ-040 flush_i and instr_ready_i both high in FULL -> no transfer, instr_valid_o=0 next cycle, state IDLE.
REQ-041 pc_i=FFFF fetch, then increment -> next mem_addr_o=0000.
REQ-042 rst_i asserted while mem_req_o=1 and mem_ack_i=1 -> no capture, instr_valid_o=0, pc_op_o=11.
